// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - MIPS-style ID decode, load-use/redirect hazard control and ID/EX, EX/MEM, MEM/WB control registers
module pipe_controller #(
  parameter int ALUOP_W   = 4,
  parameter int REGADDR_W = 5
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [31:0]          Instr,
  input  logic                 InstrValid,
  input  logic                 Redirect,
  output logic                 ID_JumpReg,
  output logic                 ID_Jump,
  output logic                 ID_Branch,
  output logic [ALUOP_W-1:0]   EX_ALUOp,
  output logic                 EX_ALUSrc,
  output logic                 MEM_MemRead,
  output logic                 MEM_MemWrite,
  output logic [1:0]           MEM_LoadType,
  output logic [1:0]           MEM_StoreType,
  output logic                 WB_RegWrite,
  output logic [1:0]           WB_MemToReg,
  output logic [REGADDR_W-1:0] WB_WriteReg,
  output logic                 Stall,
  output logic                 Flush,
  output logic                 IllegalOp
);
  typedef struct packed {
    logic [ALUOP_W-1:0]   alu_op;
    logic                 alu_src;
    logic                 mem_read;
    logic                 mem_write;
    logic [1:0]           load_type;
    logic [1:0]           store_type;
    logic                 reg_write;
    logic [1:0]           mem_to_reg;
    logic [REGADDR_W-1:0] write_reg;
  } ctrl_t;

  logic [5:0]           op, funct;
  logic [REGADDR_W-1:0] rs, rt, rd, dest;
  logic                 jump_reg, jump, branch, illegal, use_rs, use_rt, writes, load_use;
  logic                 unused_shamt;
  ctrl_t                dec, idex;

  logic                 ex_mem_read, ex_mem_write, ex_reg_write;
  logic [1:0]           ex_load_type, ex_store_type, ex_mem_to_reg;
  logic [REGADDR_W-1:0] ex_write_reg;
  logic                 wb_reg_write;
  logic [1:0]           wb_mem_to_reg;
  logic [REGADDR_W-1:0] wb_write_reg;
  logic                 illegal_q;

  assign op           = Instr[31:26];
  assign funct        = Instr[5:0];
  assign rs           = REGADDR_W'(Instr[25:21]);
  assign rt           = REGADDR_W'(Instr[20:16]);
  assign rd           = REGADDR_W'(Instr[15:11]);
  assign unused_shamt = ^Instr[10:6];

  always_comb begin
    dec      = '0;
    dest     = '0;
    writes   = 1'b0;
    jump_reg = 1'b0;
    jump     = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (op)
      6'h00: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        if (funct == 6'h08) begin
          jump_reg = 1'b1;
        end else begin
          writes         = 1'b1;
          dest           = rd;
          dec.mem_to_reg = 2'd1;
        end
      end
      6'h1C: begin
        use_rs         = 1'b1;
        use_rt         = 1'b1;
        writes         = 1'b1;
        dest           = rd;
        dec.alu_op     = ALUOP_W'(1);
        dec.mem_to_reg = 2'd1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: begin
        use_rs         = 1'b1;
        writes         = 1'b1;
        dest           = rt;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 2'd1;
        case (op)
          6'h0C:   dec.alu_op = ALUOP_W'(3);
          6'h0D:   dec.alu_op = ALUOP_W'(4);
          6'h0E:   dec.alu_op = ALUOP_W'(5);
          6'h0A:   dec.alu_op = ALUOP_W'(6);
          default: dec.alu_op = ALUOP_W'(2);
        endcase
      end
      6'h23, 6'h21, 6'h20: begin
        use_rs        = 1'b1;
        writes        = 1'b1;
        dest          = rt;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALUOP_W'(2);
        dec.load_type = (op == 6'h23) ? 2'd0 : (op == 6'h21) ? 2'd1 : 2'd2;
      end
      6'h2B, 6'h29, 6'h28: begin
        use_rs         = 1'b1;
        use_rt         = 1'b1;
        dec.mem_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALUOP_W'(2);
        dec.store_type = (op == 6'h2B) ? 2'd0 : (op == 6'h29) ? 2'd1 : 2'd2;
      end
      6'h04, 6'h05: begin
        use_rs     = 1'b1;
        use_rt     = 1'b1;
        branch     = 1'b1;
        dec.alu_op = (op == 6'h04) ? ALUOP_W'(7) : ALUOP_W'(8);
      end
      6'h06, 6'h07: begin
        use_rs     = 1'b1;
        branch     = 1'b1;
        dec.alu_op = (op == 6'h06) ? ALUOP_W'(9) : ALUOP_W'(10);
      end
      6'h01: begin
        // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1) are implemented
        if (Instr[20:17] == 4'd0) begin
          use_rs     = 1'b1;
          branch     = 1'b1;
          dec.alu_op = Instr[16] ? ALUOP_W'(12) : ALUOP_W'(11);
        end else begin
          illegal = 1'b1;
        end
      end
      6'h02: jump = 1'b1;
      6'h03: begin
        jump           = 1'b1;
        writes         = 1'b1;
        dest           = REGADDR_W'(31);
        dec.mem_to_reg = 2'd2;
      end
      default: illegal = 1'b1;
    endcase
    dec.write_reg = writes ? dest : '0;
    dec.reg_write = writes && (dest != '0);
  end

  assign ID_JumpReg = InstrValid && jump_reg;
  assign ID_Jump    = InstrValid && jump;
  assign ID_Branch  = InstrValid && branch;

  assign load_use = idex.mem_read && (idex.write_reg != '0) && InstrValid &&
                    ((use_rs && idex.write_reg == rs) || (use_rt && idex.write_reg == rt));
  // Redirect wins over a load-use hazard: the dependent instruction is dead anyway
  assign Stall = Rst_n && !Redirect && load_use;
  assign Flush = Rst_n && Redirect;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      idex          <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_load_type  <= 2'd0;
      ex_store_type <= 2'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 2'd0;
      ex_write_reg  <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 2'd0;
      wb_write_reg  <= '0;
      illegal_q     <= 1'b0;
    end else begin
      idex          <= (Stall || Flush || !InstrValid) ? '0 : dec;
      ex_mem_read   <= idex.mem_read;
      ex_mem_write  <= idex.mem_write;
      ex_load_type  <= idex.load_type;
      ex_store_type <= idex.store_type;
      ex_reg_write  <= idex.reg_write;
      ex_mem_to_reg <= idex.mem_to_reg;
      ex_write_reg  <= idex.write_reg;
      wb_reg_write  <= ex_reg_write;
      wb_mem_to_reg <= ex_mem_to_reg;
      wb_write_reg  <= ex_write_reg;
      illegal_q     <= InstrValid && illegal && !Redirect;
    end
  end

  assign EX_ALUOp      = idex.alu_op;
  assign EX_ALUSrc     = idex.alu_src;
  assign MEM_MemRead   = ex_mem_read;
  assign MEM_MemWrite  = ex_mem_write;
  assign MEM_LoadType  = ex_load_type;
  assign MEM_StoreType = ex_store_type;
  assign WB_RegWrite   = wb_reg_write;
  assign WB_MemToReg   = wb_mem_to_reg;
  assign WB_WriteReg   = wb_write_reg;
  assign IllegalOp     = illegal_q;
endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - table, directed and randomized checks of pipe_controller against a rule-level model
module tb_pipe_controller;
  logic        Clk = 1'b0;
  logic        Rst_n, InstrValid, Redirect;
  logic [31:0] Instr;
  logic        ID_JumpReg, ID_Jump, ID_Branch, EX_ALUSrc, MEM_MemRead, MEM_MemWrite;
  logic [3:0]  EX_ALUOp;
  logic [1:0]  MEM_LoadType, MEM_StoreType, WB_MemToReg;
  logic        WB_RegWrite, Stall, Flush, IllegalOp;
  logic [4:0]  WB_WriteReg;

  pipe_controller #(.ALUOP_W(4), .REGADDR_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr(Instr), .InstrValid(InstrValid), .Redirect(Redirect),
    .ID_JumpReg(ID_JumpReg), .ID_Jump(ID_Jump), .ID_Branch(ID_Branch),
    .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_LoadType(MEM_LoadType), .MEM_StoreType(MEM_StoreType),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg), .WB_WriteReg(WB_WriteReg),
    .Stall(Stall), .Flush(Flush), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src, mem_read, mem_write;
    logic [1:0] lt, st;
    logic       reg_write;
    logic [1:0] mtr;
    logic [4:0] wr;
    logic       jr, j, br, ill, use_rs, use_rt;
  } ctl_t;

  typedef enum {K_ILL, K_R, K_JR, K_MUL, K_IMM, K_LD, K_ST, K_BR2, K_BR1, K_RI, K_J, K_JAL} kind_t;

  typedef struct {
    logic [31:0] instr;
    logic        valid, redirect;
    logic [4:0]  exp;  // {jr, j, br, stall, flush}
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ctl_t m_ex = '0, m_mem = '0, m_wb = '0;
  logic m_ill = 1'b0;
  logic [5:0] op_pool [22] = '{6'h00, 6'h00, 6'h1C, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h23, 6'h21, 6'h20,
                               6'h2B, 6'h29, 6'h28, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03, 6'h3F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ctl_t ref_decode(input logic [31:0] ins);
    ctl_t       c = '0;
    kind_t      k;
    logic [5:0] op = ins[31:26];
    logic [4:0] rt = ins[20:16];
    logic [4:0] dest = 5'd0;
    case (op)
      6'h00:                             k = (ins[5:0] == 6'h08) ? K_JR : K_R;
      6'h1C:                             k = K_MUL;
      6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: k = K_IMM;
      6'h23, 6'h21, 6'h20:               k = K_LD;
      6'h2B, 6'h29, 6'h28:               k = K_ST;
      6'h04, 6'h05:                      k = K_BR2;
      6'h06, 6'h07:                      k = K_BR1;
      6'h01:                             k = (rt < 5'd2) ? K_RI : K_ILL;
      6'h02:                             k = K_J;
      6'h03:                             k = K_JAL;
      default:                           k = K_ILL;
    endcase
    c.use_rs = !(k inside {K_ILL, K_J, K_JAL});
    c.use_rt = k inside {K_R, K_JR, K_MUL, K_ST, K_BR2};
    c.ill    = (k == K_ILL);
    c.jr     = (k == K_JR);
    c.j      = k inside {K_J, K_JAL};
    c.br     = k inside {K_BR2, K_BR1, K_RI};
    case (k)
      K_MUL:        c.alu_op = 4'd1;
      K_IMM:        c.alu_op = (op == 6'h08) ? 4'd2 : (op == 6'h0A) ? 4'd6 : 4'(op - 6'd9);
      K_LD, K_ST:   c.alu_op = 4'd2;
      K_BR2, K_BR1: c.alu_op = 4'(op + 6'd3);
      K_RI:         c.alu_op = 4'(5'd11 + rt);
      default:      c.alu_op = 4'd0;
    endcase
    c.alu_src   = k inside {K_IMM, K_LD, K_ST};
    c.mem_read  = (k == K_LD);
    c.mem_write = (k == K_ST);
    if (k == K_LD) c.lt = (op[1:0] == 2'd3) ? 2'd0 : 2'(2'd2 - op[1:0]);
    if (k == K_ST) c.st = (op[1:0] == 2'd3) ? 2'd0 : 2'(2'd2 - op[1:0]);
    if (k inside {K_R, K_MUL}) dest = ins[15:11];
    else if (k inside {K_IMM, K_LD}) dest = rt;
    else if (k == K_JAL) dest = 5'd31;
    c.mtr       = (k == K_JAL) ? 2'd2 : (k inside {K_R, K_MUL, K_IMM}) ? 2'd1 : 2'd0;
    c.wr        = dest;
    c.reg_write = (dest != 5'd0);
    return c;
  endfunction

  // One clock: drive, check ID-stage combinational outputs, advance model, check registered outputs.
  task automatic cycle(input logic [31:0] ins, input logic v, input logic rdr, input logic rst,
                       output logic [4:0] comb);
    ctl_t d;
    logic haz, e_st, e_fl;
    Instr = ins; InstrValid = v; Redirect = rdr; Rst_n = rst;
    #1;
    d    = v ? ref_decode(ins) : '0;
    haz  = v && m_ex.mem_read && m_ex.wr != 5'd0 &&
           ((d.use_rs && m_ex.wr == ins[25:21]) || (d.use_rt && m_ex.wr == ins[20:16]));
    e_st = rst && !rdr && haz;
    e_fl = rst && rdr;
    comb = {ID_JumpReg, ID_Jump, ID_Branch, Stall, Flush};
    chk("Stall", Stall, e_st);
    chk("Flush", Flush, e_fl);
    chk("ID_flags", {ID_JumpReg, ID_Jump, ID_Branch}, {d.jr, d.j, d.br});
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (e_st || e_fl) ? '0 : d;
      m_ill = d.ill && !rdr;
    end
    @(posedge Clk);
    #1;
    chk("EX_ALUOp", EX_ALUOp, m_ex.alu_op);
    chk("EX_ALUSrc", EX_ALUSrc, m_ex.alu_src);
    chk("MEM_ctl", {MEM_MemRead, MEM_MemWrite, MEM_LoadType, MEM_StoreType},
        {m_mem.mem_read, m_mem.mem_write, m_mem.lt, m_mem.st});
    chk("WB_RegWrite", WB_RegWrite, m_wb.reg_write);
    chk("WB_MemToReg", WB_MemToReg, m_wb.mtr);
    chk("WB_WriteReg", WB_WriteReg, m_wb.wr);
    chk("IllegalOp", IllegalOp, m_ill);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op = op_pool[$urandom_range(0, 21)];
    logic [5:0] fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, fn};
  endfunction

  initial begin
    vec_t       tbl [14];
    logic [4:0] c;
    tbl[0]  = '{32'h20080005, 1'b1, 1'b0, 5'b00000};  // ADDI $8,$0,5
    tbl[1]  = '{32'h8D090000, 1'b1, 1'b0, 5'b00000};  // LW $9,0($8)
    tbl[2]  = '{32'h01295020, 1'b1, 1'b0, 5'b00010};  // ADD $10,$9,$9 stalls
    tbl[3]  = '{32'h01295020, 1'b1, 1'b0, 5'b00000};  // ADD held, bubble in EX
    tbl[4]  = '{32'h0C000010, 1'b1, 1'b0, 5'b01000};  // JAL
    tbl[5]  = '{32'h11290004, 1'b1, 1'b0, 5'b00100};  // BEQ
    tbl[6]  = '{32'h03E00008, 1'b1, 1'b0, 5'b10000};  // JR $31
    tbl[7]  = '{32'h8D090000, 1'b1, 1'b0, 5'b00000};  // LW $9
    tbl[8]  = '{32'h01295020, 1'b1, 1'b1, 5'b00001};  // dependent ADD under redirect
    tbl[9]  = '{32'hFC000000, 1'b1, 1'b0, 5'b00000};  // opcode 0x3F
    tbl[10] = '{32'hFC000000, 1'b0, 1'b0, 5'b00000};  // 0x3F not valid
    tbl[11] = '{32'h04020000, 1'b1, 1'b0, 5'b00000};  // REGIMM rt=2 illegal
    tbl[12] = '{32'h04210003, 1'b1, 1'b0, 5'b00100};  // BGEZ
    tbl[13] = '{32'hA1090000, 1'b1, 1'b0, 5'b00000};  // SB

    // Reset with hostile inputs: Stall/Flush must stay low
    cycle(32'h01295020, 1'b1, 1'b1, 1'b0, c);
    chk("rst_comb", c[1:0], 2'b00);
    cycle(32'h8D090000, 1'b1, 1'b0, 1'b0, c);
    chk("rst_EX_ALUOp", EX_ALUOp, 4'd0);
    chk("rst_WB_RegWrite", WB_RegWrite, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].instr, tbl[i].valid, tbl[i].redirect, 1'b1, c);
      chk($sformatf("tbl%0d_comb", i), c, tbl[i].exp);
    end
    for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0, 1'b0, 1'b1, c);

    // ADDI $8,$0,5 through the pipe
    cycle(32'h20080005, 1'b1, 1'b0, 1'b1, c);
    chk("addi_EX_ALUOp", EX_ALUOp, 4'd2);
    chk("addi_EX_ALUSrc", EX_ALUSrc, 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
    chk("addi_WB", {WB_RegWrite, WB_WriteReg, WB_MemToReg}, {1'b1, 5'd8, 2'd1});

    // JAL writes $31 with PC+8
    cycle(32'h0C000040, 1'b1, 1'b0, 1'b1, c);
    chk("jal_ID_Jump", c[3], 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
    chk("jal_WB", {WB_RegWrite, WB_WriteReg, WB_MemToReg}, {1'b1, 5'd31, 2'd2});

    // Illegal opcode: one-cycle pulse
    cycle(32'hFC000000, 1'b1, 1'b0, 1'b1, c);
    chk("ill_pulse", IllegalOp, 1'b1);
    cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
    chk("ill_clear", IllegalOp, 1'b0);
    cycle(32'hFC000000, 1'b0, 1'b0, 1'b1, c);
    chk("ill_invalid", IllegalOp, 1'b0);

    // SB then reset: the store must never reach MEM
    cycle(32'hA1090000, 1'b1, 1'b0, 1'b1, c);
    cycle(32'h0, 1'b0, 1'b0, 1'b0, c);
    chk("rst_all", {EX_ALUOp, EX_ALUSrc, MEM_MemRead, MEM_MemWrite, MEM_LoadType, MEM_StoreType,
                    WB_RegWrite, WB_MemToReg, WB_WriteReg, IllegalOp}, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 1'b1, c);
      chk("rst_no_store", MEM_MemWrite, 1'b0);
    end

    for (int i = 0; i < 500; i++)
      cycle(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) != 0, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
